// File: rtl/serial_log_fpmul_pkg.sv
// Shared types and format constants for the byte-serial Mitchell log-domain FP multiplier.
package serial_log_fpmul_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CALC = 2'd2,
    ST_SEND = 2'd3
  } slf_state_e;

  function automatic int slf_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  function automatic int slf_exp_ones(input int exp_w);
    return (1 << exp_w) - 1;
  endfunction

  // Quiet NaN: sign 0, exponent all-ones, only the mantissa MSB set.
  function automatic logic [63:0] slf_qnan(input int exp_w, input int man_w);
    return (64'(slf_exp_ones(exp_w)) << man_w) | (64'd1 << (man_w - 1));
  endfunction

endpackage

// File: rtl/serial_log_fpmul_core.sv
// Combinational Mitchell-approximation multiply: mantissas add in the log domain,
// optional constant compensation, with NaN/inf/zero/overflow/underflow handling.
module log_fpmul_core
  import serial_log_fpmul_pkg::*;
#(
  parameter int EXP_W   = 5,
  parameter int MAN_W   = 10,
  parameter int COMP_SH = 4
) (
  input  logic [EXP_W+MAN_W:0] i_a,
  input  logic [EXP_W+MAN_W:0] i_b,
  input  logic                 i_mode,
  output logic [EXP_W+MAN_W:0] o_res,
  output logic [3:0]           o_flags
);

  localparam int W = 1 + EXP_W + MAN_W;
  localparam logic [EXP_W-1:0] EXP_ONES = EXP_W'(slf_exp_ones(EXP_W));
  localparam logic [EXP_W+1:0] BIAS_X   = (EXP_W+2)'(slf_bias(EXP_W));
  localparam logic [63:0]      QNAN64   = slf_qnan(EXP_W, MAN_W);
  localparam logic [W-1:0]     QNAN     = QNAN64[W-1:0];
  localparam logic [MAN_W+1:0] HIDDEN   = {2'b01, {MAN_W{1'b0}}};
  localparam logic [MAN_W+1:0] COMP     = HIDDEN >> COMP_SH;

  logic                    w_sign;
  logic [EXP_W-1:0]        w_ea, w_eb;
  logic [MAN_W-1:0]        w_ma, w_mb;
  logic                    w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan, w_nan;
  logic [MAN_W+1:0]        w_sum;
  logic                    w_carry, w_sat;
  logic [MAN_W-1:0]        w_man;
  logic signed [EXP_W+1:0] w_exp;
  logic                    w_ovf, w_unf;

  assign w_sign = i_a[W-1] ^ i_b[W-1];
  assign w_ea   = i_a[W-2:MAN_W];
  assign w_eb   = i_b[W-2:MAN_W];
  assign w_ma   = i_a[MAN_W-1:0];
  assign w_mb   = i_b[MAN_W-1:0];

  assign w_a_zero = (w_ea == '0);
  assign w_b_zero = (w_eb == '0);
  assign w_a_inf  = (w_ea == EXP_ONES) && (w_ma == '0);
  assign w_b_inf  = (w_eb == EXP_ONES) && (w_mb == '0);
  assign w_a_nan  = (w_ea == EXP_ONES) && (w_ma != '0);
  assign w_b_nan  = (w_eb == EXP_ONES) && (w_mb != '0);
  assign w_nan    = w_a_nan | w_b_nan | (w_a_inf & w_b_zero) | (w_b_inf & w_a_zero);

  // Sum carries two guard bits; dropping bit MAN_W is the subtraction of 2^MAN_W.
  assign w_sum   = {2'b00, w_ma} + {2'b00, w_mb} + (i_mode ? COMP : '0);
  assign w_carry = |w_sum[MAN_W+1:MAN_W];
  assign w_sat   = w_sum[MAN_W+1];
  assign w_man   = w_sat ? {MAN_W{1'b1}} : w_sum[MAN_W-1:0];

  assign w_exp = {2'b00, w_ea} + {2'b00, w_eb} - BIAS_X + {{(EXP_W+1){1'b0}}, w_carry};
  assign w_ovf = !w_exp[EXP_W+1] && (w_exp[EXP_W:0] >= {1'b0, EXP_ONES});
  assign w_unf = w_exp[EXP_W+1] || (w_exp == '0);

  always_comb begin
    o_res   = {w_sign, w_exp[EXP_W-1:0], w_man};
    o_flags = 4'b0000;
    if (w_nan) begin
      o_res   = QNAN;
      o_flags = 4'b1000;
    end else if (w_a_inf || w_b_inf) begin
      o_res   = {w_sign, EXP_ONES, {MAN_W{1'b0}}};
      o_flags = 4'b0100;
    end else if (w_a_zero || w_b_zero) begin
      o_res   = {w_sign, {(EXP_W+MAN_W){1'b0}}};
    end else if (w_ovf) begin
      o_res   = {w_sign, EXP_ONES, {MAN_W{1'b0}}};
      o_flags = 4'b0110;
    end else if (w_unf) begin
      o_res   = {w_sign, {(EXP_W+MAN_W){1'b0}}};
      o_flags = 4'b0001;
    end
  end

endmodule

// File: rtl/serial_log_fpmul.sv
// Byte-serial wrapper: gathers operand bytes LSB first, runs the log-domain core,
// and streams the result back out LSB first under valid/ready handshaking.
module serial_log_fpmul
  import serial_log_fpmul_pkg::*;
#(
  parameter int EXP_W   = 5,
  parameter int MAN_W   = 10,
  parameter int COMP_SH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       mode,
  input  logic [7:0] in_a,
  input  logic [7:0] in_b,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic [3:0] flags
);

  localparam int W     = 1 + EXP_W + MAN_W;
  localparam int NB    = W / 8;
  localparam int CNT_W = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NB - 1);

  slf_state_e           r_state;
  logic [CNT_W-1:0]     r_icnt, r_ocnt;
  logic [NB-1:0][7:0]   r_a, r_b, r_res;
  logic                 r_mode;
  logic [3:0]           r_flags;
  logic [7:0]           r_out_data;
  logic                 r_out_valid, r_out_last;
  logic [W-1:0]         w_res;
  logic [3:0]           w_flags;

  log_fpmul_core #(
    .EXP_W  (EXP_W),
    .MAN_W  (MAN_W),
    .COMP_SH(COMP_SH)
  ) u_core (
    .i_a    (r_a),
    .i_b    (r_b),
    .i_mode (r_mode),
    .o_res  (w_res),
    .o_flags(w_flags)
  );

  assign in_ready  = (r_state == ST_IDLE) || (r_state == ST_LOAD);
  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;
  assign flags     = r_flags;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_icnt      <= '0;
      r_ocnt      <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_res       <= '0;
      r_mode      <= 1'b0;
      r_flags     <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else if (ena) begin
      case (r_state)
        ST_IDLE, ST_LOAD: begin
          if (in_valid) begin
            r_a[r_icnt] <= in_a;
            r_b[r_icnt] <= in_b;
            if (r_state == ST_IDLE) begin
              r_mode  <= mode;
              r_flags <= '0;
            end
            if (r_icnt == LAST) begin
              r_icnt  <= '0;
              r_state <= ST_CALC;
            end else begin
              r_icnt  <= r_icnt + 1'b1;
              r_state <= ST_LOAD;
            end
          end
        end
        ST_CALC: begin
          r_res   <= w_res;
          r_flags <= w_flags;
          r_state <= ST_SEND;
        end
        ST_SEND: begin
          // First SEND cycle loads byte 0 into the output register.
          if (!r_out_valid) begin
            r_out_data  <= r_res[0];
            r_out_valid <= 1'b1;
            r_out_last  <= (NB == 1);
            r_ocnt      <= '0;
          end else if (out_ready) begin
            if (r_out_last) begin
              r_out_valid <= 1'b0;
              r_out_last  <= 1'b0;
              r_state     <= ST_IDLE;
            end else begin
              r_ocnt     <= r_ocnt + 1'b1;
              r_out_data <= r_res[r_ocnt + 1'b1];
              r_out_last <= ((r_ocnt + 1'b1) == LAST);
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
